// File: rtl/aes_job_arbiter_if.sv
// Handshake bundle between the two job requesters, the AES round controller and
// aes_job_arbiter.
//   master : environment side (requesters + AES core); drives requests, core_done, err_clr
//   slave  : arbiter side; drives ready/done pulses, core_start/core_en_de, grant, status
interface aes_job_arbiter_if;
  // Requester 0
  logic req0_valid;
  logic req0_en_de;
  logic req0_ready;
  logic req0_done;
  // Requester 1
  logic req1_valid;
  logic req1_en_de;
  logic req1_ready;
  logic req1_done;
  // AES core control
  logic core_start;
  logic core_en_de;
  logic core_done;
  // Datapath mux select and status
  logic grant;
  logic busy;
  logic timeout_err;
  logic err_clr;

  modport master (
    output req0_valid, req0_en_de, req1_valid, req1_en_de, core_done, err_clr,
    input  req0_ready, req0_done, req1_ready, req1_done,
    input  core_start, core_en_de, grant, busy, timeout_err
  );

  modport slave (
    input  req0_valid, req0_en_de, req1_valid, req1_en_de, core_done, err_clr,
    output req0_ready, req0_done, req1_ready, req1_done,
    output core_start, core_en_de, grant, busy, timeout_err
  );
endinterface

// File: rtl/aes_job_arbiter.sv
// Two-requester round-robin arbiter in front of a single AES round controller.
// One job at a time: IDLE -> START (accept + core_start) -> WAIT (core running,
// watchdog armed) -> DONE (completion pulse to owner) -> IDLE.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; drops any in-flight job silently
//   bus.slave   req{0,1}_valid/en_de in, req{0,1}_ready/done out,
//               core_start/core_en_de out, core_done in, grant/busy/timeout_err out,
//               err_clr in
// Parameter:
//   TMO_W       watchdog width; a job times out after 2^TMO_W-1 WAIT cycles without
//               core_done (TMO_W >= 2)
// Every output is a flop; next-state values are computed in one always_comb block.
module aes_job_arbiter #(
  parameter int unsigned TMO_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  aes_job_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // The counter reaches all-ones on the edge leaving the cycle in which it holds
  // all-ones minus one; that edge is the expiry point.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [1:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic             en_de_q, en_de_d;
  logic             ready0_q, ready0_d;
  logic             ready1_q, ready1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;

  logic             win;
  logic             terr_set;
  logic             finish;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    en_de_d  = en_de_q;
    ready0_d = 1'b0;
    ready1_d = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    start_d  = 1'b0;
    terr_set = 1'b0;
    finish   = 1'b0;

    // Round-robin: on contention the requester not granted last time wins;
    // otherwise whichever one is asking.
    if (bus.req0_valid && bus.req1_valid) begin
      win = ~last_q;
    end else begin
      win = bus.req1_valid;
    end

    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          state_d  = START;
          grant_d  = win;
          en_de_d  = win ? bus.req1_en_de : bus.req0_en_de;
          ready0_d = ~win;
          ready1_d = win;
          start_d  = 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // core_done has priority over a coincident watchdog expiry.
        if (bus.core_done) begin
          finish = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          finish   = 1'b1;
          terr_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (finish) begin
          state_d = DONE;
          done0_d = ~grant_q;
          done1_d = grant_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = grant_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    // A new timeout beats a simultaneous clear request.
    if (terr_set) begin
      terr_d = 1'b1;
    end else if (bus.err_clr) begin
      terr_d = 1'b0;
    end else begin
      terr_d = terr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      en_de_q  <= 1'b0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      en_de_q  <= en_de_d;
      ready0_q <= ready0_d;
      ready1_q <= ready1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.req0_ready  = ready0_q;
  assign bus.req1_ready  = ready1_q;
  assign bus.req0_done   = done0_q;
  assign bus.req1_done   = done1_q;
  assign bus.core_start  = start_q;
  assign bus.core_en_de  = en_de_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter (TMO_W = 4): a per-cycle vector table for the
// basic job flow and arbitration, then hand-written sequences for latency, timeout,
// reset-in-flight and round-robin.
module tb_aes_job_arbiter;
  localparam int unsigned TMO_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_job_arbiter_if bus ();

  aes_job_arbiter #(.TMO_W(TMO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic dual_seen = 1'b0;

  // Output vector order: {rdy0, rdy1, dn0, dn1, start, en_de, grant, busy, terr}
  typedef struct {
    logic       v0, e0, v1, e1, cd, clr;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic logic [8:0] outs();
    return {bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done, bus.core_start,
            bus.core_en_de, bus.grant, bus.busy, bus.timeout_err};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v0, input logic e0, input logic v1, input logic e1,
                        input logic cd, input logic clr);
    bus.req0_valid = v0;
    bus.req0_en_de = e0;
    bus.req1_valid = v1;
    bus.req1_en_de = e1;
    bus.core_done  = cd;
    bus.err_clr    = clr;
  endtask

  task automatic add(input logic v0, input logic e0, input logic v1, input logic e1,
                     input logic cd, input logic clr, input logic [8:0] exp, input string name);
    vec_t v;
    v.v0 = v0; v.e0 = e0; v.v1 = v1; v.e1 = e1; v.cd = cd; v.clr = clr;
    v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  // Never two ready or two done pulses in one cycle.
  always @(negedge clk) begin
    if (rst_n && ((bus.req0_ready && bus.req1_ready) || (bus.req0_done && bus.req1_done)))
      dual_seen = 1'b1;
  end

  initial begin
    logic       bad;
    logic       found;
    logic [1:0] exp_g;

    // Table: one row per cycle, inputs applied then outputs checked after the edge.
    add(1, 1, 0, 0, 0, 0, 9'b100011010, "v01_accept_req0_enc");
    add(0, 0, 0, 0, 0, 0, 9'b000001010, "v02_wait");
    add(0, 0, 0, 0, 1, 0, 9'b001001010, "v03_done0");
    add(0, 0, 0, 0, 0, 0, 9'b000001000, "v04_idle_hold");
    add(1, 0, 1, 1, 0, 0, 9'b010011110, "v05_contend_req1_wins");
    add(1, 0, 0, 1, 1, 0, 9'b000001110, "v06_core_done_in_start_ignored");
    add(1, 0, 1, 0, 0, 0, 9'b000001110, "v07_inputs_ignored_in_wait");
    add(1, 0, 0, 0, 1, 0, 9'b000101110, "v08_done1");
    add(1, 0, 0, 0, 1, 0, 9'b000001100, "v09_done_to_idle");
    add(1, 0, 0, 0, 0, 0, 9'b100010010, "v10_accept_req0_dec");
    add(0, 0, 0, 0, 0, 0, 9'b000000010, "v11_wait");
    add(0, 0, 0, 0, 1, 0, 9'b001000010, "v12_done0");
    add(0, 0, 0, 0, 1, 0, 9'b000000000, "v13_idle");
    add(0, 0, 0, 0, 1, 0, 9'b000000000, "v14_core_done_in_idle_ignored");
    add(0, 0, 0, 0, 0, 1, 9'b000000000, "v15_clr_when_clear");
    add(0, 0, 1, 1, 0, 0, 9'b010011110, "v16_accept_req1_alone");
    add(0, 0, 0, 0, 0, 0, 9'b000001110, "v17_wait");
    add(0, 0, 0, 0, 1, 0, 9'b000101110, "v18_done1");
    add(0, 0, 0, 0, 0, 0, 9'b000001100, "v19_idle");

    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 16'(outs()), 16'h0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", 16'(outs()), 16'h0);

    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].v0, vq[i].e0, vq[i].v1, vq[i].e1, vq[i].cd, vq[i].clr);
      tick();
      check(vq[i].name, 16'(outs()), 16'(vq[i].exp));
    end
    set_in(0, 0, 0, 0, 0, 0);

    // Single job, core_done 12 cycles after core_start.
    set_in(1, 1, 0, 0, 0, 0);
    tick();
    check("lat_accept", 16'({bus.req0_ready, bus.req1_ready, bus.core_start, bus.core_en_de,
                              bus.grant}), 16'b10110);
    set_in(0, 0, 0, 0, 0, 0);
    bad = 1'b0;
    repeat (12) begin
      tick();
      if (bus.req0_done || bus.req1_done || !bus.busy) bad = 1'b1;
    end
    check("lat_wait_quiet", 16'(bad), 16'h0);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    check("lat_done_next_cycle", 16'({bus.req0_done, bus.req1_done, bus.busy, bus.core_en_de,
                                       bus.grant}), 16'b10110);
    tick();
    check("lat_busy_low", 16'(bus.busy), 16'h0);

    // Watchdog expiry: 15 WAIT cycles, then DONE with timeout_err.
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    check("tmo_accept", 16'({bus.req0_ready, bus.core_start}), 16'b11);
    set_in(0, 0, 0, 0, 0, 0);
    bad = 1'b0;
    repeat (15) begin
      tick();
      if (bus.req0_done || bus.req1_done || bus.timeout_err || !bus.busy) bad = 1'b1;
    end
    check("tmo_wait_quiet", 16'(bad), 16'h0);
    tick();
    check("tmo_expire", 16'({bus.req0_done, bus.req1_done, bus.timeout_err, bus.busy}),
          16'b1011);
    tick();
    check("tmo_back_idle", 16'({bus.busy, bus.timeout_err}), 16'b01);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("tmo_err_clr", 16'(bus.timeout_err), 16'h0);

    // core_done on the expiry edge: normal completion, no error.
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    repeat (15) tick();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    check("tmo_coincident_done", 16'({bus.req0_done, bus.timeout_err, bus.busy}), 16'b101);
    tick();
    check("tmo_coincident_idle", 16'({bus.busy, bus.timeout_err}), 16'b00);

    // Expiry with err_clr held: set wins, then the clear takes effect.
    set_in(1, 0, 0, 0, 0, 1);
    tick();
    bus.req0_valid = 1'b0;
    repeat (15) tick();
    tick();
    check("tmo_set_beats_clr", 16'({bus.req0_done, bus.timeout_err}), 16'b11);
    tick();
    check("tmo_clr_after_set", 16'(bus.timeout_err), 16'h0);
    set_in(0, 0, 0, 0, 0, 0);

    // Reset mid-WAIT on a req1 job: outputs clear at once, no done pulse.
    set_in(0, 0, 1, 1, 0, 0);
    tick();
    set_in(0, 0, 0, 1, 0, 0);
    repeat (2) tick();
    check("rst_pre_wait", 16'(outs()), 16'b000001110);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", 16'(outs()), 16'h0);
    bus.core_done = 1'b1;
    bad = 1'b0;
    repeat (2) begin
      tick();
      if (outs() != 9'h0) bad = 1'b1;
    end
    check("rst_held_quiet", 16'(bad), 16'h0);
    set_in(1, 1, 1, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("rst_then_req0_priority", 16'({bus.req0_ready, bus.req1_ready, bus.grant,
                                          bus.core_en_de}), 16'b1001);
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    check("rst_job_done0", 16'({bus.req0_done, bus.req1_done}), 16'b10);
    tick();

    // Both valid continuously from reset: grants alternate 0,1,0,1.
    rst_n = 1'b0;
    set_in(1, 0, 1, 1, 0, 0);
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        tick();
        if (bus.core_start) found = 1'b1;
      end
      exp_g = (j % 2 == 0) ? 2'b00 : 2'b11;
      if (!found) begin
        check($sformatf("rr_start_timeout_job%0d", j), 16'h0, 16'h1);
      end else begin
        check($sformatf("rr_grant_job%0d", j), 16'({bus.grant, bus.core_en_de}), 16'(exp_g));
      end
      tick();
      bus.core_done = 1'b1;
      tick();
      bus.core_done = 1'b0;
    end
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check("no_dual_pulses", 16'(dual_seen), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_job_arbiter.md
AES_JOB_ARBITER -- requirements
Module: aes_job_arbiter

Interface
REQ-001 Parameter TMO_W, default 8, width of the watchdog counter; timeout limit is 2^TMO_W-1 cycles.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid  in  1  requester 0 job request; held until req0_ready.
REQ-005 req0_en_de  in  1  requester 0 direction (1 encrypt, 0 decrypt); stable while req0_valid.
REQ-006 req0_ready  out  1  one-cycle accept pulse to requester 0.
REQ-007 req0_done  out  1  one-cycle job-complete pulse to requester 0.
REQ-008 req1_valid, req1_en_de, req1_ready, req1_done: same as REQ-004..007 for requester 1.
REQ-009 core_start  out  1  one-cycle start pulse to the AES round controller.
REQ-010 core_en_de  out  1  latched direction driven to the AES core.
REQ-011 core_done  in  1  one-cycle completion pulse from the AES core.
REQ-012 grant  out  1  index of owning requester; selects the datapath input/output mux.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 timeout_err  out  1  sticky watchdog error flag.
REQ-015 err_clr  in  1  synchronous clear of timeout_err.

Function
REQ-016 All outputs shall be registered; FSM states IDLE, START, WAIT, DONE.
REQ-017 IDLE: if any reqN_valid, the arbiter shall select a winner, latch grant and core_en_de from the winner's en_de, and enter START next edge; otherwise stay IDLE.
REQ-018 Arbitration shall be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins.
REQ-019 last-grant register shall reset to 1 so requester 0 wins the first contended arbitration.
REQ-020 START (exactly one cycle): reqN_ready=1 for the winner only and core_start=1; next state WAIT.
REQ-021 WAIT: watchdog counter shall clear on entry and increment each cycle; core_done -> DONE.
REQ-022 WAIT: counter reaching 2^TMO_W-1 without core_done shall set timeout_err and go to DONE.
REQ-023 core_done and watchdog expiry in the same cycle: core_done wins, timeout_err not set.
REQ-024 DONE (exactly one cycle): reqN_done=1 for grant, last-grant updated to grant; next state IDLE.
REQ-025 Latency: valid sampled in IDLE at edge t -> ready/core_start high during cycle t+1; core_done at edge u -> reqN_done high during cycle u+1; minimum IDLE-to-IDLE of one job is 4 cycles.
REQ-026 grant and core_en_de shall hold constant from START through DONE; reqN_valid/en_de changes after accept are ignored.
REQ-027 core_done in IDLE, START or DONE shall be ignored.
REQ-028 err_clr clears timeout_err next edge; simultaneous set and err_clr: set wins.
REQ-029 A requester dropping valid in IDLE before being accepted shall not be granted.
REQ-030 No reqN_ready or reqN_done shall ever pulse for both requesters in the same cycle.

Reset
REQ-031 rst_n low, at any time including mid-job, shall force IDLE, counter 0, last-grant 1, and all outputs 0 (grant 0, core_en_de 0, timeout_err 0) immediately; an in-flight job is dropped without reqN_done.
REQ-032 After rst_n deasserts, the first arbitration shall occur no earlier than the first rising edge with rst_n high.

Verification
REQ-033 req0_valid=1, en_de=1 alone; core_done 12 cycles after core_start -> req0_ready and core_start same cycle, core_en_de=1, grant=0, req0_done 1 cycle after core_done, busy low after.
REQ-034 Both valid continuously from reset, 4 jobs -> grant sequence 0,1,0,1; no dual ready/done pulses.
REQ-035 TMO_W=4, core_done never arrives -> timeout_err=1 after 15 WAIT cycles, reqN_done pulses, FSM back to IDLE; err_clr -> timeout_err=0 next cycle.
REQ-036 core_done coincident with counter=15 (TMO_W=4) -> timeout_err stays 0, normal done.
REQ-037 rst_n asserted during WAIT -> all outputs 0 immediately, no reqN_done; next request served normally with grant=0 priority.
REQ-038 core_done pulse while IDLE, req1_en_de toggled during WAIT -> no state change, core_en_de unchanged.
